// File: rtl/timing_sequencer_if.sv
// timing_sequencer_if: control inputs and phase strobe outputs
// of the multi-phase timing sequencer, grouped with master/slave views.
interface timing_sequencer_if #(
    parameter int PHASE_COUNT = 4,
    parameter int LEN_WIDTH   = 4
);
    localparam int IDX_WIDTH = $clog2(PHASE_COUNT);

    logic                             enable;
    logic                             mode_oneshot;
    logic                             start;
    logic [PHASE_COUNT*LEN_WIDTH-1:0] phase_len;
    logic [PHASE_COUNT-1:0]           phase_out;
    logic [IDX_WIDTH-1:0]             phase_index;
    logic                             phase_first;
    logic                             busy;
    logic                             cycle_done;

    modport master (
        output enable,
        output mode_oneshot,
        output start,
        output phase_len,
        input  phase_out,
        input  phase_index,
        input  phase_first,
        input  busy,
        input  cycle_done
    );

    modport slave (
        input  enable,
        input  mode_oneshot,
        input  start,
        input  phase_len,
        output phase_out,
        output phase_index,
        output phase_first,
        output busy,
        output cycle_done
    );
endinterface

// File: rtl/timing_sequencer.sv
// timing_sequencer: one-hot phase strobes with per-phase dwell lengths.
// Define TIMING_SEQUENCER_GAP_EN to insert one idle GAP cycle per transition.
module timing_sequencer #(
    parameter int PHASE_COUNT = 4,
    parameter int LEN_WIDTH   = 4
) (
    input logic               clock,
    input logic               reset_n,
    timing_sequencer_if.slave bus
);
    localparam int IDX_WIDTH = $clog2(PHASE_COUNT);
    localparam logic [IDX_WIDTH-1:0] LAST =
        IDX_WIDTH'(PHASE_COUNT - 1);
    localparam logic [PHASE_COUNT-1:0] ONE =
        PHASE_COUNT'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef TIMING_SEQUENCER_GAP_EN
        GAP  = 2'd2,
`endif
        RUN  = 2'd1
    } state_t;

    state_t                 state_q, state_n;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_n;
    logic                   mode_q, mode_n;
    logic [PHASE_COUNT-1:0] out_q, out_n;
    logic [IDX_WIDTH-1:0]   idx_q, idx_n;
    logic                   first_q, first_n;
    logic                   busy_q, busy_n;
    logic                   done_q, done_n;
    logic                   adv;
    logic                   enter;
    logic [IDX_WIDTH-1:0]   tgt;
    logic [LEN_WIDTH-1:0]   lens [PHASE_COUNT];

    for (genvar g = 0; g < PHASE_COUNT; g++) begin : g_len
        assign lens[g] = bus.phase_len[g*LEN_WIDTH +: LEN_WIDTH];
    end

    // Next state/outputs; everything holds while enable is low.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        mode_n  = mode_q;
        out_n   = out_q;
        idx_n   = idx_q;
        first_n = first_q;
        busy_n  = busy_q;
        done_n  = done_q;
        adv     = 1'b0;
        enter   = 1'b0;
        tgt     = idx_q;
        if (bus.enable) begin
            first_n = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!bus.mode_oneshot || bus.start) begin
                        enter  = 1'b1;
                        tgt    = '0;
                        mode_n = bus.mode_oneshot;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_n = cnt_q - 1'b1;
                    end else begin
`ifdef TIMING_SEQUENCER_GAP_EN
                        state_n = GAP;
                        out_n   = '0;
`else
                        adv = 1'b1;
`endif
                    end
                end
`ifdef TIMING_SEQUENCER_GAP_EN
                GAP: adv = 1'b1;
`endif
                default: state_n = IDLE;
            endcase
            // Move to next phase, wrap, or finish a one-shot run.
            if (adv) begin
                if (idx_q != LAST) begin
                    enter = 1'b1;
                    tgt   = idx_q + 1'b1;
                end else if (!mode_q) begin
                    enter  = 1'b1;
                    tgt    = '0;
                    mode_n = bus.mode_oneshot;
                end else begin
                    state_n = IDLE;
                    out_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            // Phase entry samples its length; zero acts as one.
            if (enter) begin
                state_n = RUN;
                idx_n   = tgt;
                out_n   = ONE << tgt;
                first_n = 1'b1;
                busy_n  = 1'b1;
                cnt_n   = (lens[tgt] == '0) ? '0
                        : lens[tgt] - 1'b1;
            end
            done_n = (state_n == RUN) && (idx_n == LAST)
                  && (cnt_n == '0);
        end
    end

    // State and registered outputs with async active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            mode_q  <= mode_n;
            out_q   <= out_n;
            idx_q   <= idx_n;
            first_q <= first_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.phase_out   = out_q;
    assign bus.phase_index = idx_q;
    assign bus.phase_first = first_q;
    assign bus.busy        = busy_q;
    assign bus.cycle_done  = done_q;
endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer: directed steps with an expected-output queue
// built from phase lengths, compared one entry per clock.
module tb_timing_sequencer;
    logic clock;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   lens[4];
    logic [8:0] sb[$];

    timing_sequencer_if #(.PHASE_COUNT(4), .LEN_WIDTH(4)) bus ();

    timing_sequencer #(.PHASE_COUNT(4), .LEN_WIDTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [8:0] obs();
        return {bus.phase_out, bus.phase_index,
                bus.phase_first, bus.busy, bus.cycle_done};
    endfunction

    task automatic chk(input string tag,
                       input logic [8:0] got,
                       input logic [8:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b",
                   tag, got, want);
        end
    endtask

    task automatic push(input logic [3:0] o, input int i,
                        input logic f, input logic b,
                        input logic d);
        logic [1:0] ix;
        ix = 2'(i);
        sb.push_back({o, ix, f, b, d});
    endtask

    task automatic push_phase(input int i, input int l,
                              input bit fin);
        int le;
        logic [3:0] o;
        le = (l == 0) ? 1 : l;
        o = 4'(1 << i);
        for (int c = 0; c < le; c++)
            push(o, i, c == 0, 1'b1, fin && (c == le - 1));
`ifdef TIMING_SEQUENCER_GAP_EN
        push(4'b0000, i, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    task automatic push_period();
        for (int i = 0; i < 4; i++)
            push_phase(i, lens[i], i == 3);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain_n(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            step();
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: queue empty", tag);
            end else begin
                chk(tag, obs(), sb.pop_front());
            end
        end
    endtask

    task automatic drain(input string tag);
        drain_n(sb.size(), tag);
    endtask

    task automatic set_lens(input int a, input int b,
                            input int c, input int d);
        lens[0] = a;
        lens[1] = b;
        lens[2] = c;
        lens[3] = d;
        bus.phase_len = {4'(d), 4'(c), 4'(b), 4'(a)};
    endtask

    // Assert reset between edges, check outputs cleared at once.
    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 chk(tag, obs(), 9'b0);
        #3 reset_n = 1'b1;
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.enable       = 1'b0;
        bus.mode_oneshot = 1'b0;
        bus.start        = 1'b0;
        bus.phase_len    = '0;
        step();

        set_lens(1, 2, 3, 4);
        bus.enable = 1'b1;
        do_reset("rst_init");
        push_period();
        push_period();
        drain("cont_1234");

        push_phase(0, 1, 1'b0);
        push_phase(1, 2, 1'b0);
        push(4'b0100, 2, 1'b1, 1'b1, 1'b0);
        drain("to_ph2");
        do_reset("rst_mid");
        push_period();
        drain("restart");

        set_lens(2, 2, 2, 2);
        bus.mode_oneshot = 1'b1;
        do_reset("rst_os");
        push(4'b0000, 0, 1'b0, 1'b0, 1'b0);
        push(4'b0000, 0, 1'b0, 1'b0, 1'b0);
        drain("os_idle");
        push_period();
        push(4'b0000, 3, 1'b0, 1'b0, 1'b0);
        push(4'b0000, 3, 1'b0, 1'b0, 1'b0);
        push(4'b0000, 3, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        drain_n(1, "os_go");
        bus.start = 1'b0;
        drain_n(1, "os_run");
        bus.start = 1'b1;
        drain_n(1, "os_restart");
        bus.start = 1'b0;
        drain("os_end");

        set_lens(1, 1, 0, 1);
        bus.mode_oneshot = 1'b0;
        do_reset("rst_len0");
        push_period();
        push_period();
        drain("len0");

        set_lens(2, 3, 1, 1);
        do_reset("rst_frz");
        push_phase(0, 2, 1'b0);
        push(4'b0010, 1, 1'b1, 1'b1, 1'b0);
        drain("frz_pre");
        bus.enable = 1'b0;
        for (int k = 0; k < 5; k++)
            push(4'b0010, 1, 1'b1, 1'b1, 1'b0);
        drain("frz_hold");
        bus.enable = 1'b1;
        push(4'b0010, 1, 1'b0, 1'b1, 1'b0);
        push(4'b0010, 1, 1'b0, 1'b1, 1'b0);
`ifdef TIMING_SEQUENCER_GAP_EN
        push(4'b0000, 1, 1'b0, 1'b1, 1'b0);
`endif
        push_phase(2, 1, 1'b0);
        push_phase(3, 1, 1'b1);
        push_phase(0, 2, 1'b0);
        drain("frz_resume");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule

// File: doc/timing_sequencer.md
Name: timing_sequencer

Overview:
- Parametrised multi-phase timing generator. Produces one-hot phase strobes, each held for a programmable number of clock cycles.
- Supports continuous (free-running) and one-shot (start/done handshake) modes, plus clock-enable freeze.
- Drives sequential control in lab datapaths (scan multiplexing, staged load/compute/store control) where equal-length phases are insufficient.

Parameters:
- PHASE_COUNT, 4, number of phases; legal range 2..16.
- LEN_WIDTH, 4, width of each per-phase length field; phase length range 1..2^LEN_WIDTH-1.
- IDX_WIDTH, $clog2(PHASE_COUNT), width of phase_index; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  advance when 1; freeze all state and outputs when 0.
- mode_oneshot  input  1  0 = continuous, 1 = one-shot.
- start  input  1  one-shot trigger, sampled only in IDLE.
- phase_len  input  PHASE_COUNT*LEN_WIDTH  packed lengths; phase i at bits [i*LEN_WIDTH +: LEN_WIDTH].
- phase_out  output  PHASE_COUNT  one-hot active-phase strobes.
- phase_index  output  IDX_WIDTH  binary index of the active phase.
- phase_first  output  1  high on the first cycle of every phase.
- busy  output  1  high while in RUN (or GAP).
- cycle_done  output  1  1-cycle pulse on the last cycle of the final phase.

Behaviour:
- All outputs are registered.
- Reset state:
  - State IDLE.
  - phase_out=0, phase_index=0, phase_first=0, busy=0, cycle_done=0.
  - Dwell counter=0, mode latch=0.
  - Reset is asynchronous and is honoured mid-run; it aborts immediately.
- States: IDLE, RUN, GAP (GAP exists only with the optional feature).
- IDLE -> RUN, on an edge with enable=1, when either:
  - mode_oneshot=0, or
  - mode_oneshot=1 and start=1.
  - On that edge: mode_oneshot is latched, phase 0 is entered, phase_out=1, phase_first=1, busy=1.
- Phase length:
  - The length L is sampled from phase_len on the phase-entry edge; later changes do not affect the current phase.
  - L=0 is treated as L=1.
  - Phase i stays active for exactly L enabled cycles; the dwell counter loads L-1 and counts down to 0.
- Phase advance: on the edge where the counter is 0, the sequencer moves to phase i+1. phase_out shifts left by one, phase_index increments, and phase_first=1 for one cycle.
- Final phase (PHASE_COUNT-1), last cycle:
  - cycle_done=1 during that cycle.
  - Continuous (latched mode 0): the next edge wraps to phase 0, with no idle cycle in between. The mode is re-latched from mode_oneshot at the wrap.
  - One-shot (latched mode 1): the next edge goes to IDLE. phase_out=0, busy=0, phase_index holds its last value.
- start while busy is ignored; start pulses are never queued.
- enable=0 freezes the counter, state and all outputs, including phase_first and cycle_done, which stay high if they were high. Operation resumes exactly where it stopped.
- A continuous cycle period is the sum of all effective phase lengths.
- No two phase_out bits are ever high simultaneously.

Optional Feature:
- Macro: TIMING_SEQUENCER_GAP_EN.
- When defined:
  - Every phase transition, including the wrap and the exit to IDLE, inserts one GAP cycle.
  - During GAP: phase_out=0, busy=1, phase_index holds the outgoing index, phase_first=0, cycle_done=0.
  - The next phase enters on the edge after GAP. This guarantees non-overlapping strobes for external latches.
  - The continuous period becomes sum(L)+PHASE_COUNT.
- When undefined: the GAP state and its logic are absent, and phase transitions are back-to-back as described above.

Test Plan:
- Continuous, lengths {1,2,3,4}, enable=1 after reset release -> phase_out sequence 0001,0010x2,0100x3,1000x4, repeating with period 10; cycle_done high on the 10th cycle of each period; phase_first high 4 times per period.
- One-shot, lengths {2,2,2,2}, start pulsed once -> busy high for exactly 8 cycles, cycle_done pulses once in cycle 8, then IDLE with phase_out=0; a start pulse at cycle 3 has no effect.
- Length 0 in phase 2 with others 1 -> phase 2 lasts 1 cycle; period = 4.
- enable deasserted for 5 cycles in the middle of phase 1 (L=3, after 1 cycle) -> outputs frozen for those 5 cycles, then phase 1 completes its remaining 2 cycles.
- reset_n asserted mid-phase 2 -> outputs zero immediately, without waiting for a clock edge; after release the sequencer restarts at phase 0.
- With TIMING_SEQUENCER_GAP_EN, lengths {1,1,1,1} continuous -> 0001,0000,0010,0000,0100,0000,1000,0000, period 8, busy constantly 1.
